load_store_unit: RTL and testbench

Data-memory access stage for the pipelined hart. Sits between execute (ALU address, rs2 data) and the realistic data-memory port that replaces the combinational dmem model. Converts byte/half/word loads and stores into word-aligned masked requests. Runs a valid/ready handshake with variable-latency memory. Returns shifted, sign- or zero-extended load data to writeback, with stall and trap indications.

---
 rtl/lsu_pkg.sv | 14 +
 rtl/lsu_align.sv | 26 ++
 rtl/load_store_unit.sv | 113 +++++++++++
 tb/tb_load_store_unit.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// lsu_pkg: shared state encoding, access-size and byte-mask constants for the load/store unit
package lsu_pkg;
  typedef enum logic [1:0] {IDLE, REQ, WAIT, RESP} state_t;
  localparam logic [1:0] SIZE_B = 2'b00;
  localparam logic [1:0] SIZE_H = 2'b01;
  localparam logic [1:0] SIZE_W = 2'b10;
  localparam logic [3:0] MASK_B = 4'b0001;
  localparam logic [3:0] MASK_HL = 4'b0011;
  localparam logic [3:0] MASK_HH = 4'b1100;
  localparam logic [3:0] MASK_W = 4'b1111;
  function automatic logic misaligned(input logic [1:0] size, input logic [1:0] lo);
    return (size == SIZE_H && lo[0]) || (size == SIZE_W && lo != 2'b00) || size == 2'b11;
  endfunction
endpackage

// File: rtl/lsu_align.sv
// lsu_align: combinational byte-lane steering (mask, store shift, load shift and extend)
module lsu_align
  import lsu_pkg::*;
(
  input  logic [1:0]  size,
  input  logic [1:0]  lo,
  input  logic        is_unsigned,
  input  logic [31:0] wdata,
  input  logic [31:0] rdata,
  output logic [3:0]  mask,
  output logic [31:0] wdata_lane,
  output logic [31:0] rdata_ext
);
  logic [4:0] sh;
  logic [31:0] sr;
  // lane shift is 8*lo for bytes, 16*lo[1] for halves, none for words
  always_comb begin
    sh = size == SIZE_B ? {lo, 3'b000} : size == SIZE_H ? {lo[1], 4'b0000} : 5'd0;
    mask = size == SIZE_B ? MASK_B << lo : size == SIZE_H ? (lo[1] ? MASK_HH : MASK_HL) : MASK_W;
    wdata_lane = size == SIZE_B ? {24'd0, wdata[7:0]} << sh :
                 size == SIZE_H ? {16'd0, wdata[15:0]} << sh : wdata;
    sr = rdata >> sh;
    rdata_ext = size == SIZE_B ? {{24{~is_unsigned & sr[7]}}, sr[7:0]} :
                size == SIZE_H ? {{16{~is_unsigned & sr[15]}}, sr[15:0]} : sr;
  end
endmodule

// File: rtl/load_store_unit.sv
// load_store_unit: byte/half/word memory stage with valid/ready memory handshake; LSU_MISALIGN_TRAP_EN enables misalign/illegal-size traps
module load_store_unit
  import lsu_pkg::*;
(
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_req_valid,
  output logic        o_req_ready,
  input  logic        i_req_wen,
  input  logic [31:0] i_req_addr,
  input  logic [31:0] i_req_wdata,
  input  logic [1:0]  i_req_size,
  input  logic        i_req_unsigned,
  output logic        o_rsp_valid,
  output logic [31:0] o_rsp_rdata,
  output logic        o_rsp_trap,
  output logic        o_mem_req_valid,
  input  logic        i_mem_req_ready,
  output logic [31:0] o_mem_addr,
  output logic        o_mem_ren,
  output logic        o_mem_wen,
  output logic [31:0] o_mem_wdata,
  output logic [3:0]  o_mem_mask,
  input  logic        i_mem_rsp_valid,
  input  logic [31:0] i_mem_rsp_rdata
);
  state_t state, state_n;
  logic [29:0] addr_q;
  logic [1:0] lo_q, size_q, size_n, lo_n;
  logic wen_q, uns_q, bad;
  logic [31:0] wdata_q, rdata_q, wdata_lane, rdata_ext;
  logic [3:0] mask;
  logic in_req;
  lsu_align u_align (
    .size(size_q),
    .lo(lo_q),
    .is_unsigned(uns_q),
    .wdata(wdata_q),
    .rdata(i_mem_rsp_rdata),
    .mask(mask),
    .wdata_lane(wdata_lane),
    .rdata_ext(rdata_ext)
  );
`ifdef LSU_MISALIGN_TRAP_EN
  logic trap_q;
  // incoming request keeps its raw size/offset; bad ones are diverted to a trap response
  always_comb begin
    size_n = i_req_size;
    lo_n = i_req_addr[1:0];
    bad = misaligned(i_req_size, i_req_addr[1:0]);
  end
  // trap flag latched at acceptance, only visible while responding
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) trap_q <= 1'b0;
    else if (state == IDLE && i_req_valid) trap_q <= bad;
  end
  assign o_rsp_trap = state == RESP && trap_q;
`else
  // without traps, size 11 becomes a word and the offset is forced aligned to the size
  always_comb begin
    size_n = i_req_size == 2'b11 ? SIZE_W : i_req_size;
    lo_n = size_n == SIZE_B ? i_req_addr[1:0] : size_n == SIZE_H ? {i_req_addr[1], 1'b0} : 2'b00;
    bad = 1'b0;
  end
  assign o_rsp_trap = 1'b0;
`endif
  // state register
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state <= IDLE;
    else state <= state_n;
  end
  // next-state logic: accept, request, wait for memory, one-cycle response
  always_comb begin
    state_n = state;
    case (state)
      IDLE: if (i_req_valid) state_n = bad ? RESP : REQ;
      REQ: if (i_mem_req_ready) state_n = WAIT;
      WAIT: if (i_mem_rsp_valid) state_n = RESP;
      default: state_n = IDLE;
    endcase
  end
  // request fields latched on acceptance; load result captured on memory completion
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      addr_q <= '0;
      lo_q <= '0;
      size_q <= '0;
      wen_q <= 1'b0;
      uns_q <= 1'b0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else if (state == IDLE && i_req_valid) begin
      addr_q <= i_req_addr[31:2];
      lo_q <= lo_n;
      size_q <= size_n;
      wen_q <= i_req_wen;
      uns_q <= i_req_unsigned;
      wdata_q <= i_req_wdata;
    end else if (state == WAIT && i_mem_rsp_valid) begin
      rdata_q <= wen_q ? 32'd0 : rdata_ext;
    end
  end
  assign in_req = state == REQ;
  assign o_req_ready = state == IDLE;
  assign o_rsp_valid = state == RESP;
  assign o_rsp_rdata = rdata_q;
  assign o_mem_req_valid = in_req;
  assign o_mem_addr = in_req ? {addr_q, 2'b00} : 32'd0;
  assign o_mem_ren = in_req && !wen_q;
  assign o_mem_wen = in_req && wen_q;
  assign o_mem_wdata = in_req ? wdata_lane : 32'd0;
  assign o_mem_mask = in_req ? mask : 4'd0;
endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit: scoreboard bench for load_store_unit (follows LSU_MISALIGN_TRAP_EN when defined)
module tb_load_store_unit;
  logic i_clk = 1'b0;
  logic i_rst_n = 1'b0;
  logic i_req_valid = 1'b0;
  logic o_req_ready;
  logic i_req_wen = 1'b0;
  logic [31:0] i_req_addr = '0;
  logic [31:0] i_req_wdata = '0;
  logic [1:0] i_req_size = '0;
  logic i_req_unsigned = 1'b0;
  logic o_rsp_valid;
  logic [31:0] o_rsp_rdata;
  logic o_rsp_trap;
  logic o_mem_req_valid;
  logic i_mem_req_ready = 1'b0;
  logic [31:0] o_mem_addr;
  logic o_mem_ren;
  logic o_mem_wen;
  logic [31:0] o_mem_wdata;
  logic [3:0] o_mem_mask;
  logic i_mem_rsp_valid = 1'b0;
  logic [31:0] i_mem_rsp_rdata = '0;

  load_store_unit dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n),
    .i_req_valid(i_req_valid), .o_req_ready(o_req_ready), .i_req_wen(i_req_wen),
    .i_req_addr(i_req_addr), .i_req_wdata(i_req_wdata), .i_req_size(i_req_size),
    .i_req_unsigned(i_req_unsigned), .o_rsp_valid(o_rsp_valid), .o_rsp_rdata(o_rsp_rdata),
    .o_rsp_trap(o_rsp_trap), .o_mem_req_valid(o_mem_req_valid), .i_mem_req_ready(i_mem_req_ready),
    .o_mem_addr(o_mem_addr), .o_mem_ren(o_mem_ren), .o_mem_wen(o_mem_wen),
    .o_mem_wdata(o_mem_wdata), .o_mem_mask(o_mem_mask), .i_mem_rsp_valid(i_mem_rsp_valid),
    .i_mem_rsp_rdata(i_mem_rsp_rdata)
  );

  always #5 i_clk = ~i_clk;

  int checks = 0;
  int errors = 0;
  logic [32:0] exp_q[$];
  logic [32:0] e;
  logic [31:0] last_rdata = '0;
  int lat, pulses;
  logic mem_seen, stable, busy_ok;
  logic [31:0] seen_addr, seen_wdata;
  logic [3:0] seen_mask;
  logic seen_ren, seen_wen;

  task automatic tick;
    @(posedge i_clk);
    #1;
  endtask

  // response scoreboard: every o_rsp_valid pulse must match the oldest expected response
  always @(posedge i_clk) begin
    #1;
    if (o_rsp_valid) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL rsp_unexpected got rdata=%h trap=%b, expected no response", o_rsp_rdata, o_rsp_trap);
      end else begin
        e = exp_q.pop_front();
        if ({o_rsp_rdata, o_rsp_trap} !== e) begin
          errors++;
          $display("FAIL rsp got rdata=%h trap=%b, expected rdata=%h trap=%b", o_rsp_rdata, o_rsp_trap, e[32:1], e[0]);
        end
      end
    end
  end

  // drives one request and acts as the memory; records what the unit did
  task automatic run_op(input logic wen, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [1:0] size, input logic uns, input logic [31:0] rword,
                        input int rdy_wait, input int rsp_wait, input logic [31:0] exp_rdata,
                        input logic exp_trap);
    int rc, ta;
    rc = 0;
    ta = -1;
    exp_q.push_back({exp_rdata, exp_trap});
    if (!exp_trap) last_rdata = exp_rdata;
    lat = -1;
    pulses = 0;
    mem_seen = 1'b0;
    stable = 1'b1;
    busy_ok = 1'b1;
    i_req_wen = wen;
    i_req_addr = addr;
    i_req_wdata = wdata;
    i_req_size = size;
    i_req_unsigned = uns;
    i_req_valid = 1'b1;
    tick();
    i_req_valid = 1'b0;
    for (int t = 1; t < 60; t++) begin
      i_mem_rsp_valid = 1'b0;
      if (o_rsp_valid) begin
        pulses++;
        if (lat < 0) lat = t;
      end
      if (lat < 0 && o_req_ready) busy_ok = 1'b0;
      if (o_mem_req_valid) begin
        if (!mem_seen) begin
          mem_seen = 1'b1;
          {seen_addr, seen_mask, seen_wdata, seen_ren, seen_wen} = {o_mem_addr, o_mem_mask, o_mem_wdata, o_mem_ren, o_mem_wen};
        end else if ({o_mem_addr, o_mem_mask, o_mem_wdata, o_mem_ren, o_mem_wen} !== {seen_addr, seen_mask, seen_wdata, seen_ren, seen_wen}) begin
          stable = 1'b0;
        end
        i_mem_req_ready = rc >= rdy_wait;
        if (i_mem_req_ready) ta = t;
        rc++;
      end else begin
        i_mem_req_ready = 1'b0;
      end
      if (ta >= 0 && t == ta + rsp_wait) begin
        i_mem_rsp_valid = 1'b1;
        i_mem_rsp_rdata = rword;
      end
      if (lat >= 0 && t >= lat + 2) break;
      tick();
    end
    i_mem_rsp_valid = 1'b0;
    i_mem_req_ready = 1'b0;
  endtask

  task automatic test_reset;
    #2;
    checks++;
    if (o_req_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %b expected 1", o_req_ready); end
    checks++;
    if ({o_rsp_valid, o_rsp_trap, o_mem_req_valid, o_mem_ren, o_mem_wen} !== 5'b0) begin
      errors++;
      $display("FAIL reset_strobes got %b expected 00000", {o_rsp_valid, o_rsp_trap, o_mem_req_valid, o_mem_ren, o_mem_wen});
    end
    checks++;
    if ({o_rsp_rdata, o_mem_addr, o_mem_wdata, o_mem_mask} !== '0) begin
      errors++;
      $display("FAIL reset_data got rdata=%h addr=%h wdata=%h mask=%b expected all 0", o_rsp_rdata, o_mem_addr, o_mem_wdata, o_mem_mask);
    end
    @(negedge i_clk);
    i_rst_n = 1'b1;
    tick();
  endtask

  task automatic test_word_store;
    run_op(1'b1, 32'h0000_1000, 32'hDEAD_BEEF, 2'b10, 1'b0, 32'h0, 0, 1, 32'h0, 1'b0);
    checks++;
    if ({seen_addr, seen_mask, seen_wdata} !== {32'h0000_1000, 4'b1111, 32'hDEAD_BEEF}) begin
      errors++;
      $display("FAIL sw_fields got addr=%h mask=%b wdata=%h expected 00001000 1111 deadbeef", seen_addr, seen_mask, seen_wdata);
    end
    checks++;
    if ({seen_ren, seen_wen} !== 2'b01) begin errors++; $display("FAIL sw_strobes got ren/wen=%b expected 01", {seen_ren, seen_wen}); end
    checks++;
    if (lat !== 3) begin errors++; $display("FAIL sw_latency got %0d expected 3", lat); end
    checks++;
    if (pulses !== 1) begin errors++; $display("FAIL sw_pulses got %0d expected 1", pulses); end
  endtask

  task automatic test_byte_store;
    run_op(1'b1, 32'h0000_2003, 32'h0000_00A5, 2'b00, 1'b0, 32'h0, 0, 1, 32'h0, 1'b0);
    checks++;
    if ({seen_addr, seen_mask, seen_wdata, seen_wen} !== {32'h0000_2000, 4'b1000, 32'hA500_0000, 1'b1}) begin
      errors++;
      $display("FAIL sb_fields got addr=%h mask=%b wdata=%h wen=%b expected 00002000 1000 a5000000 1", seen_addr, seen_mask, seen_wdata, seen_wen);
    end
  endtask

  task automatic test_loads;
    run_op(1'b0, 32'h0000_1002, 32'h0, 2'b01, 1'b0, 32'h8001_1234, 0, 1, 32'hFFFF_8001, 1'b0);
    checks++;
    if ({seen_addr, seen_mask, seen_ren, seen_wen} !== {32'h0000_1000, 4'b1100, 2'b10}) begin
      errors++;
      $display("FAIL lh_fields got addr=%h mask=%b ren/wen=%b expected 00001000 1100 10", seen_addr, seen_mask, {seen_ren, seen_wen});
    end
    run_op(1'b0, 32'h0000_1002, 32'h0, 2'b01, 1'b1, 32'h8001_1234, 0, 1, 32'h0000_8001, 1'b0);
    run_op(1'b0, 32'h0000_1001, 32'h0, 2'b00, 1'b1, 32'h0000_80CD, 0, 1, 32'h0000_0080, 1'b0);
    checks++;
    if (seen_mask !== 4'b0010) begin errors++; $display("FAIL lbu_mask got %b expected 0010", seen_mask); end
    run_op(1'b0, 32'h0000_1001, 32'h0, 2'b00, 1'b0, 32'h0000_80CD, 0, 1, 32'hFFFF_FF80, 1'b0);
  endtask

  task automatic test_misaligned;
`ifdef LSU_MISALIGN_TRAP_EN
    run_op(1'b0, 32'h0000_1001, 32'h0, 2'b10, 1'b0, 32'h1122_3344, 0, 1, last_rdata, 1'b1);
    checks++;
    if (mem_seen !== 1'b0 || lat !== 1) begin errors++; $display("FAIL lw_trap got mem=%b lat=%0d expected mem=0 lat=1", mem_seen, lat); end
    run_op(1'b1, 32'h0000_1003, 32'h0000_BEEF, 2'b01, 1'b0, 32'h0, 0, 1, last_rdata, 1'b1);
    checks++;
    if (mem_seen !== 1'b0 || lat !== 1) begin errors++; $display("FAIL sh_trap got mem=%b lat=%0d expected mem=0 lat=1", mem_seen, lat); end
    run_op(1'b1, 32'h0000_1004, 32'h1234_5678, 2'b11, 1'b0, 32'h0, 0, 1, last_rdata, 1'b1);
    checks++;
    if (mem_seen !== 1'b0 || lat !== 1) begin errors++; $display("FAIL size3_trap got mem=%b lat=%0d expected mem=0 lat=1", mem_seen, lat); end
`else
    run_op(1'b0, 32'h0000_1001, 32'h0, 2'b10, 1'b0, 32'h1122_3344, 0, 1, 32'h1122_3344, 1'b0);
    checks++;
    if ({seen_addr, seen_mask} !== {32'h0000_1000, 4'b1111} || lat !== 3) begin
      errors++;
      $display("FAIL lw_align got addr=%h mask=%b lat=%0d expected 00001000 1111 3", seen_addr, seen_mask, lat);
    end
    run_op(1'b1, 32'h0000_1003, 32'h0000_BEEF, 2'b01, 1'b0, 32'h0, 0, 1, 32'h0, 1'b0);
    checks++;
    if ({seen_mask, seen_wdata} !== {4'b1100, 32'hBEEF_0000}) begin
      errors++;
      $display("FAIL sh_align got mask=%b wdata=%h expected 1100 beef0000", seen_mask, seen_wdata);
    end
    run_op(1'b1, 32'h0000_1004, 32'h1234_5678, 2'b11, 1'b0, 32'h0, 0, 1, 32'h0, 1'b0);
    checks++;
    if ({seen_addr, seen_mask, seen_wdata} !== {32'h0000_1004, 4'b1111, 32'h1234_5678}) begin
      errors++;
      $display("FAIL size3_word got addr=%h mask=%b wdata=%h expected 00001004 1111 12345678", seen_addr, seen_mask, seen_wdata);
    end
`endif
  endtask

  task automatic test_slow_memory;
    run_op(1'b0, 32'h0000_3000, 32'h0, 2'b10, 1'b0, 32'hCAFE_F00D, 5, 3, 32'hCAFE_F00D, 1'b0);
    checks++;
    if (stable !== 1'b1 || busy_ok !== 1'b1) begin errors++; $display("FAIL slow_hold got stable=%b busy_ok=%b expected 1 1", stable, busy_ok); end
    checks++;
    if (pulses !== 1 || lat !== 10) begin errors++; $display("FAIL slow_timing got pulses=%0d lat=%0d expected 1 10", pulses, lat); end
  endtask

  task automatic test_back_to_back;
    run_op(1'b1, 32'h0000_5000, 32'h0102_0304, 2'b10, 1'b0, 32'h0, 0, 1, 32'h0, 1'b0);
    run_op(1'b0, 32'h0000_5000, 32'h0, 2'b10, 1'b0, 32'h0102_0304, 0, 2, 32'h0102_0304, 1'b0);
    checks++;
    if (lat !== 4) begin errors++; $display("FAIL b2b_latency got %0d expected 4", lat); end
  endtask

  task automatic test_reset_mid;
    int seen;
    seen = 0;
    i_req_wen = 1'b0;
    i_req_addr = 32'h0000_4000;
    i_req_size = 2'b10;
    i_req_valid = 1'b1;
    tick();
    i_req_valid = 1'b0;
    i_mem_req_ready = 1'b1;
    tick();
    i_mem_req_ready = 1'b0;
    checks++;
    if ({o_req_ready, o_mem_req_valid} !== 2'b00) begin errors++; $display("FAIL wait_state got ready/memreq=%b expected 00", {o_req_ready, o_mem_req_valid}); end
    #2;
    i_rst_n = 1'b0;
    #1;
    checks++;
    if (o_req_ready !== 1'b1) begin errors++; $display("FAIL async_reset got ready=%b expected 1", o_req_ready); end
    @(negedge i_clk);
    i_rst_n = 1'b1;
    tick();
    i_mem_rsp_valid = 1'b1;
    i_mem_rsp_rdata = 32'h0000_0055;
    tick();
    i_mem_rsp_valid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      if (o_rsp_valid) seen++;
      tick();
    end
    checks++;
    if (seen !== 0 || o_req_ready !== 1'b1 || o_rsp_rdata !== 32'h0) begin
      errors++;
      $display("FAIL spurious_rsp got pulses=%0d ready=%b rdata=%h expected 0 1 00000000", seen, o_req_ready, o_rsp_rdata);
    end
  endtask

  initial begin
    test_reset();
    test_word_store();
    test_byte_store();
    test_loads();
    test_misaligned();
    test_slow_memory();
    test_back_to_back();
    test_reset_mid();
    tick();
    checks++;
    if (exp_q.size() != 0) begin errors++; $display("FAIL rsp_missing got %0d outstanding expected 0", exp_q.size()); end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
